// File: rtl/post_add_pkg.sv
// Shared constants and helpers for the SIMD post-adder pipeline.
// Lane-width helper, op encodings and lane-count legality check.
package post_add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic Z_EXT  = 1'b0;
    localparam logic Z_ACC  = 1'b1;

    function automatic bit lanes_legal(int c_width, int lanes);
        return ((lanes == 1) || (lanes == 2) || (lanes == 4)) &&
               (c_width >= lanes) && ((c_width % lanes) == 0);
    endfunction

    function automatic int lane_width(int c_width, int lanes);
        return c_width / lanes;
    endfunction

endpackage

// File: rtl/post_add_lane.sv
// One LW-bit add/sub lane with carry/borrow out.
// POST_ADD_OVF_EN adds a two's-complement overflow flag.
module post_add_lane
    import post_add_pkg::*;
#(
    parameter int LW = 48
) (
    input  logic [LW-1:0] z,
    input  logic [LW-1:0] x,
    input  logic          cin,
    input  logic          op_sub,
    output logic [LW-1:0] r,
`ifdef POST_ADD_OVF_EN
    output logic          ovf,
`endif
    output logic          cy
);

    logic [LW:0] xc;
    logic [LW:0] res;

    assign xc  = {1'b0, x} + {{LW{1'b0}}, cin};
    assign res = (op_sub == OP_SUB) ? ({1'b0, z} - xc)
                                    : ({1'b0, z} + xc);
    assign r   = res[LW-1:0];
    assign cy  = res[LW];

`ifdef POST_ADD_OVF_EN
    // Two guard bits hold the exact signed result; overflow if they disagree.
    logic [LW+1:0] zs;
    logic [LW+1:0] xs;
    logic [LW+1:0] rs;

    assign zs  = {{2{z[LW-1]}}, z};
    assign xs  = {{2{x[LW-1]}}, x} + {{(LW+1){1'b0}}, cin};
    assign rs  = (op_sub == OP_SUB) ? (zs - xs) : (zs + xs);
    assign ovf = (rs[LW+1:LW-1] != 3'b000) && (rs[LW+1:LW-1] != 3'b111);
`endif

endmodule

// File: rtl/post_adder_simd_pipe.sv
// SIMD post-adder with accumulator and valid-tracked output pipeline.
// Optional per-lane overflow output under macro POST_ADD_OVF_EN.
module post_adder_simd_pipe
    import post_add_pkg::*;
#(
    parameter int C_WIDTH    = 48,
    parameter int LANES      = 1,
    parameter int OUT_STAGES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               sync_clr,
    input  logic               in_valid,
    input  logic               op_sub,
    input  logic               op_acc,
    input  logic               cin,
    input  logic [C_WIDTH-1:0] x_in,
    input  logic [C_WIDTH-1:0] z_in,
    output logic [C_WIDTH-1:0] p_out,
    output logic [LANES-1:0]   carry_out,
`ifdef POST_ADD_OVF_EN
    output logic [LANES-1:0]   ovf,
`endif
    output logic               out_valid
);

    localparam int LW = lane_width(C_WIDTH, LANES);

    if (!lanes_legal(C_WIDTH, LANES) || (OUT_STAGES < 0) ||
        (OUT_STAGES > 4)) begin : g_bad_cfg
        $error("post_adder_simd_pipe: illegal LANES/C_WIDTH/OUT_STAGES");
    end

    logic [C_WIDTH-1:0] acc_q;
    logic [LANES-1:0]   cy_q;
    logic               v0_q;
    logic [C_WIDTH-1:0] z_sel;
    logic [C_WIDTH-1:0] sum;
    logic [LANES-1:0]   cy_nxt;
`ifdef POST_ADD_OVF_EN
    logic [LANES-1:0]   ovf_nxt;
    logic [LANES-1:0]   ovf_q;
`endif

    // Feedback comes from the accumulator itself, never from p_out.
    assign z_sel = (op_acc == Z_ACC) ? acc_q : z_in;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        post_add_lane #(
            .LW(LW)
        ) u_lane (
            .z      (z_sel[g*LW +: LW]),
            .x      (x_in[g*LW +: LW]),
            .cin    ((g == 0) ? cin : 1'b0),
            .op_sub (op_sub),
            .r      (sum[g*LW +: LW]),
`ifdef POST_ADD_OVF_EN
            .ovf    (ovf_nxt[g]),
`endif
            .cy     (cy_nxt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cy_q  <= '0;
            v0_q  <= 1'b0;
        end else if (sync_clr) begin
            acc_q <= '0;
            cy_q  <= '0;
            v0_q  <= 1'b0;
        end else if (ce) begin
            if (in_valid) begin
                acc_q <= sum;
                cy_q  <= cy_nxt;
            end
            v0_q <= in_valid;
        end
    end

`ifdef POST_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (sync_clr) begin
            ovf_q <= '0;
        end else if (ce && in_valid) begin
            ovf_q <= ovf_nxt;
        end
    end
`endif

    if (OUT_STAGES == 0) begin : g_direct
        assign p_out     = acc_q;
        assign carry_out = cy_q;
        assign out_valid = v0_q;
`ifdef POST_ADD_OVF_EN
        assign ovf       = ovf_q;
`endif
    end else begin : g_pipe
        logic [OUT_STAGES-1:0][C_WIDTH-1:0] p_q;
        logic [OUT_STAGES-1:0][LANES-1:0]   c_q;
        logic [OUT_STAGES-1:0]              v_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_q <= '0;
                c_q <= '0;
                v_q <= '0;
            end else if (sync_clr) begin
                p_q <= '0;
                c_q <= '0;
                v_q <= '0;
            end else if (ce) begin
                p_q[0] <= acc_q;
                c_q[0] <= cy_q;
                v_q[0] <= v0_q;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    p_q[i] <= p_q[i-1];
                    c_q[i] <= c_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        assign p_out     = p_q[OUT_STAGES-1];
        assign carry_out = c_q[OUT_STAGES-1];
        assign out_valid = v_q[OUT_STAGES-1];

`ifdef POST_ADD_OVF_EN
        logic [OUT_STAGES-1:0][LANES-1:0] o_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o_q <= '0;
            end else if (sync_clr) begin
                o_q <= '0;
            end else if (ce) begin
                o_q[0] <= ovf_q;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    o_q[i] <= o_q[i-1];
                end
            end
        end

        assign ovf = o_q[OUT_STAGES-1];
`endif
    end

endmodule

// File: tb/tb_post_adder_simd_pipe.sv
// Bench for post_adder_simd_pipe: C_WIDTH=48, LANES=2, OUT_STAGES=1.
// Vector table, hand-written corner sequences, then random vs. model.
module tb_post_adder_simd_pipe;

    localparam int CW = 48;
    localparam int LN = 2;
    localparam int OS = 1;
    localparam int LW = CW / LN;
    localparam longint FULL = longint'(1) << LW;
    localparam longint HALF = longint'(1) << (LW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          sync_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          op_sub = 1'b0;
    logic          op_acc = 1'b0;
    logic          cin = 1'b0;
    logic [CW-1:0] x_in = '0;
    logic [CW-1:0] z_in = '0;
    logic [CW-1:0] p_out;
    logic [LN-1:0] carry_out;
    logic          out_valid;
`ifdef POST_ADD_OVF_EN
    logic [LN-1:0] ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    post_adder_simd_pipe #(
        .C_WIDTH    (CW),
        .LANES      (LN),
        .OUT_STAGES (OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .op_sub    (op_sub),
        .op_acc    (op_acc),
        .cin       (cin),
        .x_in      (x_in),
        .z_in      (z_in),
        .p_out     (p_out),
        .carry_out (carry_out),
`ifdef POST_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic sub, input logic acc,
                         input logic c, input logic [CW-1:0] x,
                         input logic [CW-1:0] z);
        in_valid = iv;
        op_sub   = sub;
        op_acc   = acc;
        cin      = c;
        x_in     = x;
        z_in     = z;
    endtask

    // Reference model: stage-0 snapshot plus a delay queue of OS entries.
    typedef struct packed {
        logic [CW-1:0] p;
        logic [LN-1:0] cy;
        logic          v;
        logic [LN-1:0] ov;
    } snap_t;

    snap_t s0;
    snap_t hist[$];

    function automatic void mdl_clear();
        s0 = '0;
        hist.delete();
        for (int i = 0; i <= OS; i++) hist.push_back(s0);
    endfunction

    function automatic void mdl_edge();
        snap_t  n;
        longint zu, xu, ci, r, zs, xs, rs;
        if (sync_clr) begin
            mdl_clear();
            return;
        end
        if (!ce) return;
        n   = s0;
        n.v = in_valid;
        if (in_valid) begin
            for (int l = 0; l < LN; l++) begin
                zu = op_acc ? longint'(s0.p[l*LW +: LW])
                            : longint'(z_in[l*LW +: LW]);
                xu = longint'(x_in[l*LW +: LW]);
                ci = (l == 0) ? longint'(cin) : 0;
                r  = op_sub ? zu - (xu + ci) : zu + (xu + ci);
                n.p[l*LW +: LW] = r[LW-1:0];
                n.cy[l] = (r < 0) || (r >= FULL);
                zs = (zu >= HALF) ? zu - FULL : zu;
                xs = (xu >= HALF) ? xu - FULL : xu;
                rs = op_sub ? zs - (xs + ci) : zs + (xs + ci);
                n.ov[l] = (rs > HALF - 1) || (rs < -HALF);
            end
        end
        s0 = n;
        hist.push_back(n);
        void'(hist.pop_front());
    endfunction

    function automatic logic [CW-1:0] pick();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return w[CW-1:0];
            1: return '1;
            2: return {24'h7FFFFF, 24'h7FFFFF};
            default: return {16'h0, w[7:0], 16'h0, w[15:8]};
        endcase
    endfunction

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] z;
        logic          c;
        logic          sub;
        logic [CW-1:0] ep;
        logic [LN-1:0] ecy;
        logic [LN-1:0] eov;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{48'd5, 48'd10, 1'b1, 1'b0, 48'd16, 2'b00, 2'b00};
        tbl[1] = '{48'h000111_000000, 48'h123456_FFFFFF, 1'b1, 1'b0,
                   48'h123567_000000, 2'b01, 2'b00};
        tbl[2] = '{48'h000000_000001, 48'h0, 1'b0, 1'b1,
                   48'h000000_FFFFFF, 2'b01, 2'b00};
        tbl[3] = '{48'h000002_000001, 48'hFFFFFF_000001, 1'b0, 1'b0,
                   48'h000001_000002, 2'b10, 2'b00};
        tbl[4] = '{48'h000006_000003, 48'h000005_000010, 1'b1, 1'b1,
                   48'hFFFFFF_00000C, 2'b10, 2'b00};
        tbl[5] = '{48'h000000_000001, 48'h000000_7FFFFF, 1'b0, 1'b0,
                   48'h000000_800000, 2'b00, 2'b01};

        // Reset state
        #12;
        chk("rst_p", 64'(p_out), 64'd0);
        chk("rst_cy", 64'(carry_out), 64'd0);
        chk("rst_v", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        ce    = 1'b1;
        tick();

        // Vector table, one isolated operation each
        for (int i = 0; i < 6; i++) begin
            sync_clr = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            tick();
            sync_clr = 1'b0;
            drive(1'b1, tbl[i].sub, 1'b0, tbl[i].c, tbl[i].x, tbl[i].z);
            tick();
            in_valid = 1'b0;
            repeat (OS) tick();
            chk($sformatf("vec%0d_p", i), 64'(p_out), 64'(tbl[i].ep));
            chk($sformatf("vec%0d_cy", i), 64'(carry_out), 64'(tbl[i].ecy));
            chk($sformatf("vec%0d_v", i), 64'(out_valid), 64'd1);
`ifdef POST_ADD_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].eov));
`endif
        end

        // Accumulate from clear: 3, 6, 9, 12
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        for (int k = 0; k < 4 + OS; k++) begin
            drive(k < 4, 1'b0, 1'b1, 1'b0, 48'd3, 48'hABC);
            tick();
            if (k >= OS) begin
                chk($sformatf("acc%0d_p", k), 64'(p_out),
                    64'(3 * (k - OS + 1)));
                chk($sformatf("acc%0d_v", k), 64'(out_valid), 64'd1);
            end
        end

        // sync_clr wins over a simultaneous operand
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd7, 48'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("preclr_p", 64'(p_out), 64'd8);
        sync_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 48'd5, 48'd5);
        tick();
        chk("clr_p", 64'(p_out), 64'd0);
        chk("clr_v", 64'(out_valid), 64'd0);
        chk("clr_cy", 64'(carry_out), 64'd0);
        sync_clr = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        chk("clr_drop_p", 64'(p_out), 64'd0);
        chk("clr_drop_v", 64'(out_valid), 64'd0);

        // ce=0 freezes everything for 3 cycles
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd7, 48'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd2, 48'd0);
        tick();
        chk("frz_pre_p", 64'(p_out), 64'd7);
        ce = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 48'd100, 48'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_p", k), 64'(p_out), 64'd7);
            chk($sformatf("frz%0d_v", k), 64'(out_valid), 64'd1);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("thaw_p", 64'(p_out), 64'd2);
        chk("thaw_v", 64'(out_valid), 64'd1);
        tick();
        chk("thaw_end_v", 64'(out_valid), 64'd0);

        // Async reset pulse mid-stream
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd4, 48'd0);
        tick();
        tick();
        chk("prerst_v", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p", 64'(p_out), 64'd0);
        chk("arst_cy", 64'(carry_out), 64'd0);
        chk("arst_v", 64'(out_valid), 64'd0);
        x_in = 48'd9;
        #2 rst_n = 1'b1;
        tick();
        chk("rst_lat1_v", 64'(out_valid), 64'd0);
        repeat (OS) tick();
        chk("rst_lat2_p", 64'(p_out), 64'd9);
        chk("rst_lat2_v", 64'(out_valid), 64'd1);

        // Randomized run against the model
        sync_clr = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        tick();
        mdl_clear();
        for (int n = 0; n < 800; n++) begin
            ce       = ($urandom_range(0, 9) != 0);
            sync_clr = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op_sub   = 1'($urandom_range(0, 1));
            op_acc   = ($urandom_range(0, 2) == 0);
            cin      = 1'($urandom_range(0, 1));
            x_in     = pick();
            z_in     = pick();
            @(posedge clk);
            mdl_edge();
            #1;
            chk($sformatf("rnd%0d_p", n), 64'(p_out), 64'(hist[0].p));
            chk($sformatf("rnd%0d_cy", n), 64'(carry_out), 64'(hist[0].cy));
            chk($sformatf("rnd%0d_v", n), 64'(out_valid), 64'(hist[0].v));
`ifdef POST_ADD_OVF_EN
            chk($sformatf("rnd%0d_ovf", n), 64'(ovf), 64'(hist[0].ov));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
